// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus block: register offsets within
// the 32-byte window, TCON bit positions and the default window base.
package peripheral_bus_pkg;

   localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h4000_0000;

   // Byte offsets of the registers inside the window (bits [1:0] are ignored).
   localparam logic [4:0] OFS_TH      = 5'h00;
   localparam logic [4:0] OFS_TL      = 5'h04;
   localparam logic [4:0] OFS_TCON    = 5'h08;
   localparam logic [4:0] OFS_LED     = 5'h0C;
   localparam logic [4:0] OFS_SWITCH  = 5'h10;
   localparam logic [4:0] OFS_DIGIT   = 5'h14;
   localparam logic [4:0] OFS_SYSTICK = 5'h18;

   // TCON bit indices.
   localparam int TCON_EN = 0;   // timer count enable
   localparam int TCON_IE = 1;   // interrupt enable
   localparam int TCON_IS = 2;   // interrupt status (sticky)

endpackage

// File: rtl/peripheral_timer.sv
// Reloading 32-bit timer: TH holds the reload value, TL counts up, TCON holds
// enable / irq-enable / irq-status. CPU writes win over the count, but an
// overflow coinciding with a TCON write still sets the status bit.
// Ports:
//   clk, reset        clock, async active-low reset
//   th_we/tl_we/tcon_we  per-register write strobes (already decoded)
//   wdata             store data
//   th, tl, tcon      register values
//   irq               interrupt request (= TCON status bit, a flop output)
module peripheral_timer
   import peripheral_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        th_we,
   input  logic        tl_we,
   input  logic        tcon_we,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irq
);

   logic overflow;
   logic irq_set;

   assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
   assign irq_set  = overflow && tcon[TCON_IE];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (th_we)
            th <= wdata;

         // Reload uses the TH value from before any same-cycle TH write.
         if (tl_we)
            tl <= wdata;
         else if (tcon[TCON_EN])
            tl <= overflow ? th : tl + 32'd1;

         // Overflow event is ORed into a written status bit so it is never lost.
         if (tcon_we)
            tcon <= {wdata[TCON_IS] | irq_set, wdata[TCON_IE], wdata[TCON_EN]};
         else if (irq_set)
            tcon[TCON_IS] <= 1'b1;
      end
   end

   assign irq = tcon[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral window on the core's data-memory port: timer,
// LEDs, switches, 7-segment digit and a free-running tick counter.
// Reads are combinational; writes land on the rising edge.
// Ports:
//   clk, reset     clock, async active-low reset
//   iAddr          byte address from the MEM stage
//   iMemRead/iMemWrite  access strobes
//   iWriteData     store data
//   oReadData      read data (0 when not reading a hit register)
//   oHit           address decodes to a register here
//   oIRQ           timer interrupt request
//   iSwitch        raw asynchronous switch pins
//   oLed, oDigit   LED and 7-segment registers
module peripheral_bus
   import peripheral_bus_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
   parameter int          LED_WIDTH = 8,
   parameter int          SW_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          iAddr,
   input  logic                 iMemRead,
   input  logic                 iMemWrite,
   input  logic [31:0]          iWriteData,
   output logic [31:0]          oReadData,
   output logic                 oHit,
   output logic                 oIRQ,
   input  logic [SW_WIDTH-1:0]  iSwitch,
   output logic [LED_WIDTH-1:0] oLed,
   output logic [11:0]          oDigit
);

   logic [4:0]           ofs;
   logic                 hit;
   logic                 wr;
   logic [31:0]          th, tl;
   logic [2:0]           tcon;
   logic                 irq;
   logic [LED_WIDTH-1:0] led;
   logic [11:0]          digit;
   logic [31:0]          systick;
   logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
   logic                 unused_addr;

   assign unused_addr = ^iAddr[1:0];

   assign ofs = {iAddr[4:2], 2'b00};
   // Word 7 (offset 0x1C) is inside the 32-byte window but unmapped.
   assign hit = (iAddr[31:5] == ADDR_BASE[31:5]) && (iAddr[4:2] <= 3'd6);
   assign wr  = iMemWrite && hit;

   peripheral_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .th_we   (wr && ofs == OFS_TH),
      .tl_we   (wr && ofs == OFS_TL),
      .tcon_we (wr && ofs == OFS_TCON),
      .wdata   (iWriteData),
      .th      (th),
      .tl      (tl),
      .tcon    (tcon),
      .irq     (irq)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led     <= '0;
         digit   <= '0;
         systick <= '0;
         sw_s1   <= '0;
         sw_s2   <= '0;
      end else begin
         if (wr && ofs == OFS_LED)
            led <= iWriteData[LED_WIDTH-1:0];
         if (wr && ofs == OFS_DIGIT)
            digit <= iWriteData[11:0];
         systick <= systick + 32'd1;
         sw_s1   <= iSwitch;
         sw_s2   <= sw_s1;
      end
   end

   always_comb begin
      oReadData = '0;
      if (iMemRead && hit) begin
         case (ofs)
            OFS_TH:      oReadData = th;
            OFS_TL:      oReadData = tl;
            OFS_TCON:    oReadData = {29'd0, tcon};
            OFS_LED:     oReadData = 32'(led);
            OFS_SWITCH:  oReadData = 32'(sw_s2);
            OFS_DIGIT:   oReadData = {20'd0, digit};
            OFS_SYSTICK: oReadData = systick;
            default:     oReadData = '0;
         endcase
      end
   end

   assign oHit   = hit;
   assign oIRQ   = irq;
   assign oLed   = led;
   assign oDigit = digit;

endmodule

// File: tb/tb_peripheral_bus.sv
module tb_peripheral_bus;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iAddr;
   logic        iMemRead, iMemWrite;
   logic [31:0] iWriteData;
   logic [31:0] oReadData;
   logic        oHit, oIRQ;
   logic [7:0]  iSwitch;
   logic [7:0]  oLed;
   logic [11:0] oDigit;

   int checks = 0;
   int errors = 0;

   peripheral_bus dut (
      .clk(clk), .reset(reset), .iAddr(iAddr), .iMemRead(iMemRead),
      .iMemWrite(iMemWrite), .iWriteData(iWriteData), .oReadData(oReadData),
      .oHit(oHit), .oIRQ(oIRQ), .iSwitch(iSwitch), .oLed(oLed), .oDigit(oDigit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // All stimulus changes and checks happen at negedge time.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      iAddr = a; iWriteData = d; iMemWrite = 1'b1;
      tick();
      iMemWrite = 1'b0;
   endtask

   task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      iAddr = a; iMemRead = 1'b1;
      #1;
      chk(name, oReadData, exp);
      iMemRead = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        exp_hit;
      logic [31:0] exp_data;
   } vec_t;

   // Reference model state
   logic [31:0] m_th, m_tl, m_tick;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led, m_s1, m_s2;
   logic [11:0] m_dig;

   function automatic logic m_hit(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < 32'd28;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off >= 32'd28) return 32'd0;
      case (off / 4)
         0: return m_th;
         1: return m_tl;
         2: return {29'd0, m_tcon};
         3: return {24'd0, m_led};
         4: return {24'd0, m_s2};
         5: return {20'd0, m_dig};
         6: return m_tick;
         default: return 32'd0;
      endcase
   endfunction

   vec_t rst_tab[9];

   initial begin
      logic [31:0] off, n_tl, n_th;
      logic [2:0]  n_tcon;
      logic        ovf;
      logic [32:0] sum;
      int          sel;

      reset = 1'b0; iAddr = '0; iMemRead = 0; iMemWrite = 0; iWriteData = '0; iSwitch = '0;

      for (int i = 0; i < 7; i++) rst_tab[i] = '{BASE + 32'(i * 4), 1'b1, 32'd0};
      rst_tab[7] = '{32'h4000_001C, 1'b0, 32'd0};
      rst_tab[8] = '{32'h3FFF_FFFC, 1'b0, 32'd0};

      // Reset state, read while reset is held
      tick(); tick();
      for (int i = 0; i < 9; i++) begin
         iAddr = rst_tab[i].addr; iMemRead = 1'b1;
         #1;
         chk($sformatf("rst_hit[%0d]", i), 32'(oHit), 32'(rst_tab[i].exp_hit));
         chk($sformatf("rst_rd[%0d]", i), oReadData, rst_tab[i].exp_data);
         iMemRead = 1'b0;
      end
      chk("rst_irq", 32'(oIRQ), 0);
      chk("rst_led", 32'(oLed), 0);
      chk("rst_digit", 32'(oDigit), 0);

      // SYSTICK
      reset = 1'b1;
      chk_rd("systick0", BASE + 32'h18, 32'd0);
      repeat (5) tick();
      chk_rd("systick5", BASE + 32'h18, 32'd5);

      // LED / DIGIT truncation
      bus_write(BASE + 32'h0C, 32'h1A5);
      bus_write(BASE + 32'h14, 32'hFFFF5A);
      chk("led", 32'(oLed), 32'hA5);
      chk("digit", 32'(oDigit), 32'hF5A);
      chk_rd("led_rd", BASE + 32'h0E, 32'hA5);
      chk_rd("digit_rd", BASE + 32'h14, 32'hF5A);
      chk_rd("out_of_win_rd", BASE + 32'h2C, 32'd0);

      // Switch synchroniser latency
      iSwitch = 8'h3C;
      tick();
      chk_rd("sw_1edge", BASE + 32'h10, 32'h00);
      tick();
      chk_rd("sw_2edge", BASE + 32'h10, 32'h3C);
      bus_write(BASE + 32'h10, 32'hFF);
      chk_rd("sw_ro", BASE + 32'h10, 32'h3C);

      // Timer overflow, reload and irq
      bus_write(BASE + 32'h00, 32'hFFFF_FFFE);
      bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
      bus_write(BASE + 32'h08, 32'h3);
      tick();
      chk_rd("tl_inc", BASE + 32'h04, 32'hFFFF_FFFF);
      tick();
      chk_rd("tl_reload", BASE + 32'h04, 32'hFFFF_FFFE);
      chk_rd("tcon_7", BASE + 32'h08, 32'h7);
      chk("irq_set", 32'(oIRQ), 1);
      bus_write(BASE + 32'h08, 32'h3);
      chk("irq_clr", 32'(oIRQ), 0);
      // TL is now FFFFFFFF: overflow collides with TCON write
      bus_write(BASE + 32'h08, 32'h3);
      chk_rd("coll_tcon", BASE + 32'h08, 32'h7);
      chk("coll_irq", 32'(oIRQ), 1);
      bus_write(BASE + 32'h04, 32'h5);
      chk_rd("tl_wr_wins", BASE + 32'h04, 32'h5);
      tick();
      chk_rd("tl_count", BASE + 32'h04, 32'h6);

      // Async reset mid-count
      #2 reset = 1'b0;
      #1;
      chk("arst_irq", 32'(oIRQ), 0);
      chk_rd("arst_tl", BASE + 32'h04, 32'h0);
      chk_rd("arst_tcon", BASE + 32'h08, 32'h0);
      chk("arst_led", 32'(oLed), 0);
      tick();

      // Randomized phase against reference model
      iSwitch = '0;
      tick();
      reset = 1'b1;
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_dig = 0; m_tick = 0; m_s1 = 0; m_s2 = 0;
      for (int c = 0; c < 400; c++) begin
         sel = $urandom_range(0, 9);
         if (sel < 8)       iAddr = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
         else if (sel == 8) iAddr = 32'h3FFF_FFFC;
         else               iAddr = $urandom();
         iMemRead  = ($urandom_range(0, 9) < 6);
         iMemWrite = ($urandom_range(0, 9) < 3);
         iWriteData = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
         if ($urandom_range(0, 3) == 0) iSwitch = 8'($urandom());
         #1;
         chk("r_hit", 32'(oHit), 32'(m_hit(iAddr)));
         chk("r_rd", oReadData, iMemRead ? m_read(iAddr) : 32'd0);
         chk("r_irq", 32'(oIRQ), 32'(m_tcon[2]));
         chk("r_led", 32'(oLed), 32'(m_led));
         chk("r_digit", 32'(oDigit), 32'(m_dig));

         // Next state from the register rules
         off = iAddr - BASE;
         sum = {1'b0, m_tl} + 33'd1;
         ovf = m_tcon[0] && sum[32];
         n_th = m_th; n_tl = m_tl; n_tcon = m_tcon;
         if (m_tcon[0]) n_tl = ovf ? m_th : sum[31:0];
         if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
         if (iMemWrite && off < 32'd28) begin
            case (off / 4)
               0: n_th = iWriteData;
               1: n_tl = iWriteData;
               2: n_tcon = {iWriteData[2] | (ovf & m_tcon[1]), iWriteData[1:0]};
               3: m_led = iWriteData[7:0];
               5: m_dig = iWriteData[11:0];
               default: ;
            endcase
         end
         m_s2 = m_s1; m_s1 = iSwitch;
         m_tick = m_tick + 1;
         m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
         tick();
         iMemRead = 0; iMemWrite = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/peripheral_bus.md
Name: peripheral_bus

Overview:
Memory-mapped peripheral block on the pipeline core's data-memory port, downstream of the MEM stage. It decodes the core's address/read/write strobes and serves a fixed window of peripheral registers: timer, LEDs, switches, 7-segment digit and system tick counter. Reads return data combinationally in the same cycle, so the MEM/WB register captures them at the next edge. The timer raises the core's interrupt request line. The top level muxes oReadData against data RAM using oHit.

Parameters:
ADDR_BASE, 32'h40000000, base of peripheral window (32-byte aligned)
LED_WIDTH, 8, LED output width
SW_WIDTH, 8, switch input width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
iAddr  input  32  byte address from MEM stage ALU result
iMemRead  input  1  read strobe
iMemWrite  input  1  write strobe
iWriteData  input  32  store data
oReadData  output  32  read data, combinational
oHit  output  1  iAddr decodes to a register in this block
oIRQ  output  1  timer interrupt request to core
iSwitch  input  SW_WIDTH  raw asynchronous switch pins
oLed  output  LED_WIDTH  LED register
oDigit  output  12  7-segment register {anode[3:0], seg[7:0]}

Behaviour:
- Register map (offset from ADDR_BASE; iAddr[1:0] ignored):
  - 0x00 TH, rw.
  - 0x04 TL, rw.
  - 0x08 TCON[2:0], rw: bit0 enable, bit1 irq enable, bit2 irq status.
  - 0x0C LED, rw.
  - 0x10 SWITCH, ro.
  - 0x14 DIGIT, rw.
  - 0x18 SYSTICK, ro.
- oHit = (iAddr[31:5]==ADDR_BASE[31:5]) && iAddr[4:2]<=6. Offset 0x1C and anything outside the window → oHit=0, read returns 0, writes ignored.
- Reads: oReadData = register value, zero-extended, when iMemRead && oHit; otherwise 0. Zero latency. A read and a write to the same register in the same cycle returns the old value.
- Writes: take effect at the rising clk edge when iMemWrite && oHit. Only the register's width is stored; upper bits are dropped. Writes to SWITCH and SYSTICK are ignored.
- Timer, evaluated each edge when TCON[0]=1:
  - If TL==32'hFFFFFFFF: TL←TH, and if TCON[1]=1 set TCON[2].
  - Otherwise TL←TL+1.
- Timer collisions:
  - A CPU write to TL in the same cycle overrides the increment or reload.
  - A CPU write to TCON in the same cycle as an overflow: bits[1:0] take the written value; bit2 = written bit2 OR overflow set. The event is never lost.
- oIRQ = TCON[2], registered and glitch-free. Software clears it by writing TCON with bit2=0.
- SWITCH: two-flop synchroniser on iSwitch; reads return the second stage. Pin-to-readable latency is 2 edges.
- SYSTICK: 32-bit free-running counter, +1 every edge, wraps 0xFFFFFFFF→0.
- Reset (reset=0, async): TH, TL, TCON, LED, DIGIT, SYSTICK and the synchroniser flops all clear to 0. oIRQ=0, oLed=0, oDigit=0. oReadData remains combinational (returns 0 for the registers). Reset mid-count abandons the count; no pending IRQ survives.

Decomposition:
- Shared package: register offset constants (OFS_TH … OFS_SYSTICK), TCON bit indices (TCON_EN, TCON_IE, TCON_IS), ADDR_BASE default.
- One sub-module, peripheral_timer: holds TH/TL/TCON and the overflow/collision logic; inputs are the per-register write enables and data; outputs are TH, TL, TCON and irq.
- LED, DIGIT, SYSTICK, synchroniser and read mux stay in the top module.

Test Plan:
- Reset then read each offset 0x00–0x18 → all reads 0; oHit=1 for each, oHit=0 at 0x4000001C and 0x3FFFFFFC.
- Write TH=0xFFFFFFFE, TL=0xFFFFFFFE, TCON=3 → TL reads 0xFFFFFFFF after 1 edge; after the next edge TL=0xFFFFFFFE (reload), TCON=7, oIRQ=1. Write TCON=3 → oIRQ=0 next cycle.
- Overflow edge coincides with a CPU write TCON=3 → TCON reads 7 afterwards, oIRQ stays 1. CPU write TL=5 on an increment edge → TL=5.
- Write LED=0x1A5, DIGIT=0xFFFF5A → oLed=0xA5, oDigit=0xF5A; SYSTICK reads 0 as the first read after reset, N after N edges, and wraps from 0xFFFFFFFF to 0.
- Change iSwitch 0x00→0x3C → SWITCH reads 0x00 after 1 edge, 0x3C after 2 edges; a write to 0x10 leaves the value unchanged.
- Assert reset asynchronously mid-count with oIRQ=1 → oIRQ, TL and TCON are 0 immediately without a clock edge.
